seq_muldiv: RTL and testbench

SEQ_MULDIV -- requirements
Module: seq_muldiv

---
 rtl/seq_muldiv_if.sv | 27 ++
 rtl/seq_muldiv.sv | 140 ++++++++++++++
 tb/tb_seq_muldiv.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/seq_muldiv_if.sv
// seq_muldiv_if -- operation request / result bus for seq_muldiv.
//   start, op, a, b            : request (master -> slave)
//   busy, done                 : status (slave -> master)
//   result, remainder, div_zero: result registers (slave -> master)
interface seq_muldiv_if #(
  parameter int WIDTH = 8
);
  logic               start;
  logic               op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   remainder;
  logic               div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, remainder, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, remainder, div_zero
  );
endinterface

// File: rtl/seq_muldiv.sv
// seq_muldiv -- iterative unsigned multiplier / divider, one bit per clock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : seq_muldiv_if.slave (start/op/a/b in; busy/done/result/
//                remainder/div_zero out)
// op = 0 multiplies (shift-add), op = 1 divides (restoring shift-subtract).
// Every operation takes exactly WIDTH iterations; done pulses one cycle later.
// Macro MULDIV_DIV_EN: when defined the divide datapath is built; otherwise
// op = 1 runs with normal latency and returns all-zero outputs.
module seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_muldiv_if.slave   bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_op;
  // r_opnd: multiplicand (mul) or divisor (div).
  // r_hi:   upper product half (mul) or partial remainder (div).
  // r_lo:   multiplier shifting out (mul) or dividend out / quotient in (div).
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_result;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_zero;

  logic               w_accept;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_mul_hi;
  logic [WIDTH-1:0]   w_mul_lo;
  logic [WIDTH-1:0]   w_nhi;
  logic [WIDTH-1:0]   w_nlo;

  // start is honoured in IDLE and DONE, never while iterating.
  assign w_accept = bus.start && (r_state != S_RUN);

  // Multiply step: conditionally add multiplicand to the upper half, then
  // shift the {carry, hi, lo} chain right by one.
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = {w_sum[0], r_lo[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     w_trial;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_div_hi;
  logic [WIDTH-1:0]   w_div_lo;

  // Divide step: bring in the next dividend bit and try the subtraction.
  // The difference always fits in WIDTH bits when it is kept (it is < divisor),
  // so modulo-WIDTH subtraction is enough. Divisor 0 naturally yields an
  // all-ones quotient and remainder = dividend.
  assign w_trial  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge     = (w_trial >= {1'b0, r_opnd});
  assign w_diff   = w_trial[WIDTH-1:0] - r_opnd;
  assign w_div_hi = w_ge ? w_diff : w_trial[WIDTH-1:0];
  assign w_div_lo = {r_lo[WIDTH-2:0], w_ge};

  assign w_nhi = r_op ? w_div_hi : w_mul_hi;
  assign w_nlo = r_op ? w_div_lo : w_mul_lo;
`else
  assign w_nhi = w_mul_hi;
  assign w_nlo = w_mul_lo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= 1'b0;
      r_opnd      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            // Outputs change only here, so the done cycle is the first
            // cycle they show the new values.
            if (!r_op) begin
              r_result    <= {w_nhi, w_nlo};
              r_remainder <= '0;
              r_div_zero  <= 1'b0;
            end else begin
`ifdef MULDIV_DIV_EN
              r_result    <= {{WIDTH{1'b0}}, w_nlo};
              r_remainder <= w_nhi;
              r_div_zero  <= (r_opnd == '0);
`else
              r_result    <= '0;
              r_remainder <= '0;
              r_div_zero  <= 1'b0;
`endif
            end
          end
        end
        default: begin // S_IDLE, S_DONE
          if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_op    <= bus.op;
            r_hi    <= '0;
            if (bus.op) begin
              r_opnd <= bus.b;
              r_lo   <= bus.a;
            end else begin
              r_opnd <= bus.a;
              r_lo   <= bus.b;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.remainder = r_remainder;
  assign bus.div_zero  = r_div_zero;
endmodule

// File: tb/tb_seq_muldiv.sv
// tb_seq_muldiv -- directed-vector bench for seq_muldiv (WIDTH = 8).
// Divide expectations follow the MULDIV_DIV_EN setting of the build.
module tb_seq_muldiv;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   lat;
  int   npulse;

  seq_muldiv_if #(.WIDTH(W)) u_if ();

  seq_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called in the cycle after the accepting edge (lat0 = cycles elapsed).
  // Walks to the done cycle, checking busy and that results stay frozen.
  task automatic wait_done(input int lat0, input logic [15:0] hold, output int l);
    int bad;
    bad = 0;
    l = lat0;
    while (!u_if.done && l < 30) begin
      if (!u_if.busy || u_if.result !== hold) bad++;
      @(posedge clk); #1;
      l++;
    end
    chk("busy_hold", bad, 0);
  endtask

  // Present a request now and follow it to its done cycle.
  task automatic run_op(input logic op, input logic [7:0] a, input logic [7:0] b, output int l);
    logic [15:0] hold;
    hold = u_if.result;
    u_if.start = 1'b1; u_if.op = op; u_if.a = a; u_if.b = b;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    wait_done(1, hold, l);
  endtask

  task automatic chk_out(input string tag, input int l, input logic [15:0] r,
                         input logic [7:0] rm, input logic dz);
    chk({tag, "_lat"}, l, 9);
    chk({tag, "_done"}, u_if.done, 1);
    chk({tag, "_busy"}, u_if.busy, 0);
    chk({tag, "_res"}, u_if.result, r);
    chk({tag, "_rem"}, u_if.remainder, rm);
    chk({tag, "_dz"}, u_if.div_zero, dz);
  endtask

  initial begin
    logic [15:0] hold;
    n_chk = 0; n_fail = 0;
    u_if.start = 1'b0; u_if.op = 1'b0; u_if.a = '0; u_if.b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", u_if.busy, 0);
    chk("rst_done", u_if.done, 0);
    chk("rst_res", u_if.result, 0);
    chk("rst_rem", u_if.remainder, 0);
    chk("rst_dz", u_if.div_zero, 0);
    rst_n = 1'b1;

    // 13 * 11
    run_op(1'b0, 8'd13, 8'd11, lat);
    chk_out("mul13x11", lat, 16'd143, 8'd0, 1'b0);
    @(posedge clk); #1;
    chk("mul13_pulse", u_if.done, 0);
    chk("mul13_held", u_if.result, 143);

    // 255 * 255, then 200 / 7 started in the done cycle
    run_op(1'b0, 8'd255, 8'd255, lat);
    chk_out("mul255", lat, 16'd65025, 8'd0, 1'b0);
    run_op(1'b1, 8'd200, 8'd7, lat);
`ifdef MULDIV_DIV_EN
    chk_out("div200_7", lat, 16'd28, 8'd4, 1'b0);
`else
    chk_out("div200_7", lat, 16'd0, 8'd0, 1'b0);
`endif

    // 77 / 0, then 2 * 3
    run_op(1'b1, 8'd77, 8'd0, lat);
`ifdef MULDIV_DIV_EN
    chk_out("div77_0", lat, 16'd255, 8'd77, 1'b1);
`else
    chk_out("div77_0", lat, 16'd0, 8'd0, 1'b0);
`endif
    run_op(1'b0, 8'd2, 8'd3, lat);
    chk_out("mul2x3", lat, 16'd6, 8'd0, 1'b0);
    @(posedge clk); #1;
    chk("idle_busy", u_if.busy, 0);

    // zero operand: full latency, zero product
    run_op(1'b0, 8'd0, 8'd200, lat);
    chk_out("mul0", lat, 16'd0, 8'd0, 1'b0);
    @(posedge clk); #1;

    // 5 * 6 with a start at cycle N+3 that must be ignored
    hold = u_if.result;
    u_if.start = 1'b1; u_if.op = 1'b0; u_if.a = 8'd5; u_if.b = 8'd6;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    u_if.start = 1'b1; u_if.op = 1'b1; u_if.a = 8'd9; u_if.b = 8'd9;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    wait_done(4, hold, lat);
    chk_out("ignore", lat, 16'd30, 8'd0, 1'b0);
    @(posedge clk); #1;
    chk("ignore_idle", u_if.busy, 0);

    // reset in the middle of 100 / 3
    u_if.start = 1'b1; u_if.op = 1'b1; u_if.a = 8'd100; u_if.b = 8'd3;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", u_if.busy, 0);
    chk("abort_done", u_if.done, 0);
    chk("abort_res", u_if.result, 0);
    chk("abort_rem", u_if.remainder, 0);
    chk("abort_dz", u_if.div_zero, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    npulse = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (u_if.done || u_if.busy) npulse++;
    end
    chk("abort_nodone", npulse, 0);
    run_op(1'b1, 8'd100, 8'd10, lat);
`ifdef MULDIV_DIV_EN
    chk_out("div100_10", lat, 16'd10, 8'd0, 1'b0);
`else
    chk_out("div100_10", lat, 16'd0, 8'd0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
